// File: rtl/tick_bcd_pkg.sv
// Shared definitions for the tick-driven BCD counter: FSM state encoding and digit width.
package tick_bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  function automatic logic [DIGIT_W-1:0] to_digit(input int unsigned value);
    return DIGIT_W'(value);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..max; wrap flags the terminal value so the next digit can chain.
module bcd_digit
  import tick_bcd_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] q,
  output logic               wrap
);

  // Values above max (e.g. after an upset) fall back to zero on the next enabled edge.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      if (q >= max) begin
        q <= '0;
      end else begin
        q <= q + DIGIT_W'(1);
      end
    end
  end

  assign wrap = (q == max);

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD counter advanced by prescaler ticks, gated by an IDLE/RUN/PAUSE control FSM.
module tick_bcd_counter
  import tick_bcd_pkg::*;
#(
  parameter int unsigned MAX_ONES = 9,
  parameter int unsigned MAX_TENS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [DIGIT_W-1:0] MAX_ONES_D = to_digit(MAX_ONES);
  localparam logic [DIGIT_W-1:0] MAX_TENS_D = to_digit(MAX_TENS);

  state_t             state_q;
  state_t             state_d;
  logic               bad_state;
  logic               count_en;
  logic               digit_clr;
  logic               ones_wrap;
  logic               tens_wrap;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic               carry_q;
  logic               running_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stop outranks start, so start is only honoured when stop is low.
  always_comb begin
    state_d   = state_q;
    bad_state = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (!stop && start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (!stop && start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        bad_state = 1'b1;
      end
    endcase
  end

  // Counting uses the current state, so a tick alongside stop in RUN still counts.
  assign count_en  = (state_q == RUN) && tick && !clear;
  assign digit_clr = clear || bad_state;

  bcd_digit u_ones (
    .clock (clock),
    .reset (reset),
    .clr   (digit_clr),
    .en    (count_en),
    .max   (MAX_ONES_D),
    .q     (ones_q),
    .wrap  (ones_wrap)
  );

  bcd_digit u_tens (
    .clock (clock),
    .reset (reset),
    .clr   (digit_clr),
    .en    (count_en && ones_wrap),
    .max   (MAX_TENS_D),
    .q     (tens_q),
    .wrap  (tens_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      carry_q   <= count_en && ones_wrap && tens_wrap;
      running_q <= (state_d == RUN);
    end
  end

  assign ones    = ones_q;
  assign tens    = tens_q;
  assign carry   = carry_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: a reference model queues expected outputs per edge.
module tb_tick_bcd_counter;

  localparam int MAX_ONES = 9;
  localparam int MAX_TENS = 5;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       carry;
  logic       running;
  logic [1:0] state;

  tick_bcd_counter #(
    .MAX_ONES(MAX_ONES),
    .MAX_TENS(MAX_TENS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .ones    (ones),
    .tens    (tens),
    .carry   (carry),
    .running (running),
    .state   (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic       running;
    logic [1:0] state;
  } exp_t;

  exp_t  sb[$];
  int    errors     = 0;
  int    checks     = 0;
  int    carry_seen = 0;
  int    m_state    = S_IDLE;
  int    m_ones     = 0;
  int    m_tens     = 0;
  logic  m_carry    = 1'b0;
  string phase      = "init";

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic t, input logic s, input logic p, input logic c, input logic r);
    exp_t e;
    @(negedge clock);
    tick  = t;
    start = s;
    stop  = p;
    clear = c;
    reset = r;
    if (r) begin
      m_state = S_IDLE;
      m_ones  = 0;
      m_tens  = 0;
      m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (c) begin
        m_ones = 0;
        m_tens = 0;
      end else if (m_state == S_RUN && t) begin
        if (m_ones == MAX_ONES) begin
          m_ones = 0;
          if (m_tens == MAX_TENS) begin
            m_tens  = 0;
            m_carry = 1'b1;
          end else begin
            m_tens++;
          end
        end else begin
          m_ones++;
        end
      end
      if (c) m_state = S_IDLE;
      else if (p) begin
        if (m_state == S_RUN) m_state = S_PAUSE;
      end else if (s) m_state = S_RUN;
    end
    e.ones    = 4'(m_ones);
    e.tens    = 4'(m_tens);
    e.carry   = m_carry;
    e.running = (m_state == S_RUN);
    e.state   = 2'(m_state);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("ones",    {4'b0, ones},    {4'b0, e.ones});
    check("tens",    {4'b0, tens},    {4'b0, e.tens});
    check("carry",   {7'b0, carry},   {7'b0, e.carry});
    check("running", {7'b0, running}, {7'b0, e.running});
    check("state",   {6'b0, state},   {6'b0, e.state});
    if (carry === 1'b1) carry_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Ticks at the upstream prescaler cadence: one high cycle in every 12.
  task automatic ticks(input int n);
    repeat (n) begin
      idle(11);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    phase = "reset";
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_state", {6'b0, state}, 8'd0);

    phase = "idle_ticks";
    ticks(4);
    check("ones0", {4'b0, ones}, 8'd0);
    check("idle",  {6'b0, state}, 8'd0);

    phase = "ten_ticks";
    carry_seen = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    check("ones", {4'b0, ones}, 8'd0);
    check("tens", {4'b0, tens}, 8'd1);
    check("run",  {7'b0, running}, 8'd1);
    check("no_carry", 8'(carry_seen), 8'd0);

    phase = "sixty_ticks";
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    carry_seen = 0;
    ticks(59);
    check("at59", {tens, ones}, 8'h59);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap00", {tens, ones}, 8'h00);
    check("carry_hi", {7'b0, carry}, 8'd1);
    idle(3);
    check("carry_once", 8'(carry_seen), 8'd1);
    ticks(1);
    check("ones61", {4'b0, ones}, 8'd1);

    phase = "pause";
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    idle(11);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("paused", {6'b0, state}, 8'd2);
    check("ones8",  {4'b0, ones}, 8'd8);
    ticks(3);
    check("hold8",  {4'b0, ones}, 8'd8);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check("ones9",  {4'b0, ones}, 8'd9);

    phase = "held_tick";
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ones5", {4'b0, ones}, 8'd5);

    phase = "clear_wrap";
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59);
    check("at59", {tens, ones}, 8'h59);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cnt00", {tens, ones}, 8'h00);
    check("carry0", {7'b0, carry}, 8'd0);
    check("idle", {6'b0, state}, 8'd0);
    idle(2);

    phase = "reset_mid_run";
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(23);
    check("at23", {tens, ones}, 8'h23);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst00", {tens, ones}, 8'h00);
    check("rst_idle", {6'b0, state}, 8'd0);
    ticks(2);
    check("no_count", {tens, ones}, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("start_stop_idle", {6'b0, state}, 8'd0);
    ticks(1);
    check("still00", {tens, ones}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter MAX_ONES, default 9: terminal value of the ones digit.
REQ-002 The block SHALL have parameter MAX_TENS, default 5: terminal value of the tens digit (default modulus 60).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: count enable, driven by the upstream mod-12 prescaler overflow, which is high for one cycle in every 12.
REQ-006 The block SHALL have port start, input, 1 bit: level-sampled run request.
REQ-007 The block SHALL have port stop, input, 1 bit: level-sampled pause request.
REQ-008 The block SHALL have port clear, input, 1 bit: level-sampled return to IDLE with zero count.
REQ-009 The block SHALL have port ones, output, 4 bits: registered BCD ones digit.
REQ-010 The block SHALL have port tens, output, 4 bits: registered BCD tens digit.
REQ-011 The block SHALL have port carry, output, 1 bit: registered one-cycle wrap pulse.
REQ-012 The block SHALL have port running, output, 1 bit: high while state is RUN.
REQ-013 The block SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-014 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; the unused encoding 2'b11 SHALL go to IDLE on the next edge with count zeroed.
REQ-015 Input priority SHALL be clear > stop > start, evaluated once per edge.
REQ-016 Transitions SHALL be: IDLE+start->RUN; RUN+stop->PAUSE; PAUSE+start->RUN; any state+clear->IDLE; all other cases hold the current state.
REQ-017 start in RUN, and stop in IDLE or PAUSE, SHALL be ignored; start and stop asserted together SHALL resolve as stop.
REQ-018 The count SHALL advance only when the current state is RUN, tick=1 and clear=0; the count SHALL be visible on ones/tens one edge after the tick cycle.
REQ-019 A tick that coincides with stop while in RUN SHALL still be counted, because the decision uses the current state.
REQ-020 Ones SHALL increment 0..MAX_ONES; at MAX_ONES it SHALL wrap to 0 and tens SHALL increment.
REQ-021 At ones=MAX_ONES and tens=MAX_TENS, a counted tick SHALL set both digits to 0 and pulse carry high for exactly one cycle.
REQ-022 carry SHALL be low in every cycle that is not a wrap cycle; a wrap and a clear in the same cycle SHALL yield count 00 with carry=0.
REQ-023 A tick held high for N consecutive cycles in RUN SHALL advance the count N times; no edge detection is performed on tick.
REQ-024 In IDLE and PAUSE the digits SHALL hold their values; PAUSE SHALL retain the count, and the next RUN SHALL resume from it.
REQ-025 running SHALL equal (state==RUN) and SHALL be registered with state.
REQ-026 Digits SHALL never leave the range 0..MAX; any out-of-range value (e.g. from an upset) SHALL become 0 on the next counted tick.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL set state=IDLE, ones=0, tens=0, carry=0, running=0, regardless of all other inputs.
REQ-028 Reset asserted mid-RUN SHALL discard the count; after deassertion, ticks SHALL be ignored until start is seen.

Structure
REQ-029 A shared package tick_bcd_pkg SHALL hold the state encoding constants (IDLE/RUN/PAUSE) and the BCD digit width (4).
REQ-030 One sub-module, bcd_digit, SHALL implement a single digit (inputs clock, reset, clr, en, max; outputs q, wrap); it SHALL be instantiated twice, with the ones wrap ANDed into the tens enable.
REQ-031 The FSM, the carry register and the output assignments SHALL reside in tick_bcd_counter.

Verification
REQ-032 The bench SHALL check: reset, then ticks every 12 cycles with no start -> ones=0, tens=0, state=IDLE throughout.
REQ-033 The bench SHALL check: start, then 10 ticks -> ones=0, tens=1, running=1, carry never high.
REQ-034 The bench SHALL check: start, then 60 ticks -> count 00 after the 60th tick, carry high for exactly 1 cycle; 61 ticks -> ones=1.
REQ-035 The bench SHALL check: 7 ticks, then stop coinciding with the 8th tick -> PAUSE with ones=8; 3 further ticks -> still 8; start plus 1 tick -> 9.
REQ-036 The bench SHALL check: at count 59, clear coinciding with a tick -> IDLE, count 00, carry=0.
REQ-037 The bench SHALL check: reset asserted at count 23 in RUN -> next edge gives IDLE, 00; start and stop together from IDLE -> remains IDLE.
